// File: rtl/conv_frame_ctrl.sv
// Frame controller for a 4x4 / 3x3 convolution array: loads 25 operand bytes, runs the array, drains 4 results.
// Optional RUN watchdog enabled with `define CONV_TIMEOUT_EN (TIMEOUT cycles, then ERR and back to LOAD).
module conv_frame_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [127:0] a_flat,
    output logic [71:0]  b_flat,
    output logic         active_single,
    input  logic         done_single,
    input  logic [7:0]   c11,
    input  logic [7:0]   c12,
    input  logic [7:0]   c21,
    input  logic [7:0]   c22,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         busy,
    output logic         err,
    output logic [7:0]   frames_done
);

    localparam int A_BYTES     = 16;
    localparam int B_BYTES     = 9;
    localparam int LAST_BYTE   = A_BYTES + B_BYTES - 1;
    localparam int RES_BYTES   = 4;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t      state_reg;
    logic [4:0]  byte_cnt_reg;
    logic [7:0]  a_mem   [A_BYTES];
    logic [7:0]  b_mem   [B_BYTES];
    logic [7:0]  res_mem [RES_BYTES];
    logic [1:0]  out_idx_reg;
    logic        in_ready_reg;
    logic        active_reg;
    logic        out_valid_reg;
    logic [7:0]  out_data_reg;
    logic [7:0]  frames_reg;

    logic        in_fire;
    logic        out_fire;
    logic [3:0]  b_idx;
    logic [1:0]  out_idx_next;

    assign in_fire      = in_valid && in_ready_reg;
    assign out_fire     = out_valid_reg && out_ready;
    assign b_idx        = 4'(byte_cnt_reg - 5'd16);
    assign out_idx_next = out_idx_reg + 2'd1;

`ifdef CONV_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic             err_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;

    assign err = err_reg;
`else
    // Watchdog absent: err is a constant low; TIMEOUT is referenced so both builds share one parameter list.
    assign err = 1'b0 && (TIMEOUT > 0);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < A_BYTES; gi++) begin : g_a_flat
            assign a_flat[8*gi +: 8] = a_mem[gi];
        end
        for (gi = 0; gi < B_BYTES; gi++) begin : g_b_flat
            assign b_flat[8*gi +: 8] = b_mem[gi];
        end
    endgenerate

    assign in_ready      = in_ready_reg;
    assign active_single = active_reg;
    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;
    assign frames_done   = frames_reg;
    assign busy          = (state_reg != S_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_LOAD;
            byte_cnt_reg  <= '0;
            out_idx_reg   <= '0;
            in_ready_reg  <= 1'b0;
            active_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            frames_reg    <= '0;
            for (int i = 0; i < A_BYTES; i++) a_mem[i] <= '0;
            for (int i = 0; i < B_BYTES; i++) b_mem[i] <= '0;
            for (int i = 0; i < RES_BYTES; i++) res_mem[i] <= '0;
`ifdef CONV_TIMEOUT_EN
            err_reg       <= 1'b0;
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                S_LOAD: begin
                    // in_ready comes up one cycle after reset release and stays up until the last byte lands
                    in_ready_reg <= 1'b1;
                    if (in_fire) begin
                        if (byte_cnt_reg < 5'(A_BYTES))
                            a_mem[byte_cnt_reg[3:0]] <= in_data;
                        else
                            b_mem[b_idx] <= in_data;
`ifdef CONV_TIMEOUT_EN
                        if (byte_cnt_reg == 5'd0)
                            err_reg <= 1'b0;
`endif
                        if (byte_cnt_reg == 5'(LAST_BYTE)) begin
                            byte_cnt_reg <= '0;
                            in_ready_reg <= 1'b0;
                            active_reg   <= 1'b1;
                            state_reg    <= S_RUN;
`ifdef CONV_TIMEOUT_EN
                            tmo_cnt_reg  <= '0;
`endif
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 5'd1;
                        end
                    end
                end

                S_RUN: begin
                    if (done_single) begin
                        res_mem[0]    <= c11;
                        res_mem[1]    <= c12;
                        res_mem[2]    <= c21;
                        res_mem[3]    <= c22;
                        out_data_reg  <= c11;
                        out_valid_reg <= 1'b1;
                        out_idx_reg   <= '0;
                        active_reg    <= 1'b0;
                        state_reg     <= S_DRAIN;
                    end
`ifdef CONV_TIMEOUT_EN
                    else if (tmo_cnt_reg == TMO_LAST) begin
                        active_reg <= 1'b0;
                        err_reg    <= 1'b1;
                        state_reg  <= S_ERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
`endif
                end

                S_DRAIN: begin
                    // out_data only moves on a completed transfer, so it is stable under back-pressure
                    if (out_fire) begin
                        if (out_idx_reg == 2'd3) begin
                            out_valid_reg <= 1'b0;
                            frames_reg    <= frames_reg + 8'd1;
                            in_ready_reg  <= 1'b1;
                            state_reg     <= S_LOAD;
                        end else begin
                            out_idx_reg  <= out_idx_next;
                            out_data_reg <= res_mem[out_idx_next];
                        end
                    end
                end

                S_ERR: begin
                    in_ready_reg <= 1'b1;
                    state_reg    <= S_LOAD;
                end

                default: begin
                    state_reg <= S_LOAD;
                end
            endcase
        end
    end

endmodule
